// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: shared memory port, PC/IR/MDR/A/B/ALUOut holding
// registers and a 32-entry register file. All sequencing comes from the external controller.
module multicycle_datapath #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter bit              BNE_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iord,
    input  logic             irwrite,
    input  logic             pcwrite,
    input  logic             pcwritecond,
    input  logic             bne,
    input  logic             regdst,
    input  logic             memtoreg,
    input  logic             regwrite,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic [2:0]       aluctrl,
    input  logic [1:0]       pcsource,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] aluout,
    output logic             zero
);

    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rf [32];

    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] imm_shl;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] next_pc;
    logic             branch_pol;
    logic             pc_en;

    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign waddr       = regdst ? instr[15:11] : instr[20:16];
    assign wdata       = memtoreg ? mdr : aluout;
    assign rs_data     = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_data     = (rt == 5'd0) ? '0 : rf[rt];
    assign imm_ext     = {{(WIDTH-16){instr[15]}}, instr[15:0]};
    assign imm_shl     = {imm_ext[WIDTH-3:0], 2'b00};
    assign jump_target = {pc_out[WIDTH-1:28], instr[25:0], 2'b00};

    assign src_a = alusrca ? a_reg : pc_out;

    always_comb begin
        src_b = b_reg;
        case (alusrcb)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = WIDTH'(4);
            2'b10:   src_b = imm_ext;
            default: src_b = imm_shl;
        endcase
    end

    // Unused encodings deliberately yield 0 so a controller bug shows up as a zero result.
    always_comb begin
        alu_result = '0;
        case (aluctrl)
            3'b000:  alu_result = src_a & src_b;
            3'b001:  alu_result = src_a | src_b;
            3'b010:  alu_result = src_a + src_b;
            3'b110:  alu_result = src_a - src_b;
            3'b111:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        next_pc = pc_out;
        case (pcsource)
            2'b00:   next_pc = alu_result;
            2'b01:   next_pc = aluout;
            2'b10:   next_pc = jump_target;
            default: next_pc = pc_out;
        endcase
    end

    assign branch_pol = bne & BNE_EN;
    assign pc_en      = pcwrite | (pcwritecond & (zero ^ branch_pol));

    assign mem_addr  = iord ? aluout : pc_out;
    assign mem_wdata = b_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out <= PC_RESET;
            instr  <= '0;
            mdr    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            aluout <= '0;
        end else begin
            mdr    <= mem_rdata;
            a_reg  <= rs_data;
            b_reg  <= rt_data;
            aluout <= alu_result;
            if (irwrite) instr  <= mem_rdata[31:0];
            if (pc_en)   pc_out <= next_pc;
        end
    end

    // A and B sample the pre-write contents, so a same-cycle write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwrite && (waddr != 5'd0)) begin
            rf[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: table-driven ALU vectors, hand-written multi-cycle
// sequences and random R-type traffic checked against an instruction-level register model.
module tb_multicycle_datapath;

    localparam logic [31:0] PC_RST = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst;
    logic        iord, irwrite, pcwrite, pcwritecond, bne;
    logic        regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsource;
    logic [2:0]  aluctrl;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr, mem_wdata, instr, pc_out, aluout;
    logic        zero;
    logic [31:0] mem_addr_b, mem_wdata_b, instr_b, pc_out_b, aluout_b;
    logic        zero_b;

    int          n_vec;
    int          n_err;
    logic [31:0] pc_m;
    logic [31:0] rf_m [32];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    multicycle_datapath #(.WIDTH(32), .PC_RESET(PC_RST), .BNE_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .pcwritecond(pcwritecond), .bne(bne), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluctrl(aluctrl),
        .pcsource(pcsource), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .instr(instr), .pc_out(pc_out), .aluout(aluout), .zero(zero)
    );

    multicycle_datapath #(.WIDTH(32), .PC_RESET(PC_RST), .BNE_EN(1'b0)) dut_nobne (
        .clk(clk), .rst(rst), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .pcwritecond(pcwritecond), .bne(bne), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluctrl(aluctrl),
        .pcsource(pcsource), .mem_rdata(mem_rdata), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .instr(instr_b), .pc_out(pc_out_b), .aluout(aluout_b),
        .zero(zero_b)
    );

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x + y;
            3'd6:    return x - y;
            3'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        iord = 0; irwrite = 0; pcwrite = 0; pcwritecond = 0; bne = 0;
        regdst = 0; memtoreg = 0; regwrite = 0; alusrca = 0;
        alusrcb = 2'b00; aluctrl = 3'b010; pcsource = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins);
        idle();
        mem_rdata = ins; irwrite = 1; alusrcb = 2'b01; pcwrite = 1;
        tick();
        pc_m = pc_m + 32'd4;
    endtask

    task automatic decode();
        idle();
        alusrcb = 2'b11;
        tick();
    endtask

    // lw rd, 0(r0) with the memory returning val
    task automatic load_reg(input logic [4:0] rd, input logic [31:0] val);
        fetch({6'h23, 5'd0, rd, 16'h0000});
        decode();
        idle(); alusrca = 1; alusrcb = 2'b10; tick();
        idle(); iord = 1; mem_rdata = val; tick();
        idle(); memtoreg = 1; regwrite = 1; mem_rdata = 32'h0; tick();
        if (rd != 5'd0) rf_m[rd] = val;
    endtask

    // addi r0, r, 0 drives rf[r] through A into ALUOut without writing anything back
    task automatic check_reg(input logic [4:0] r);
        fetch({6'h08, r, 5'd0, 16'h0000});
        decode();
        idle(); alusrca = 1; alusrcb = 2'b10; tick();
        check($sformatf("reg r%0d", r), aluout, rf_m[r]);
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [2:0] op, output logic [31:0] res, output logic z);
        logic [31:0] expv;
        expv = model_alu(op, rf_m[rs], rf_m[rt]);
        fetch({6'h00, rs, rt, rd, 5'd0, 6'h20});
        decode();
        idle(); alusrca = 1; aluctrl = op;
        #1 z = zero;
        tick();
        res = aluout;
        regdst = 1; regwrite = 1;
        tick();
        if (rd != 5'd0) rf_m[rd] = expv;
    endtask

    task automatic branch(input logic [4:0] rs, input logic [4:0] rt, input logic bne_v,
                          output logic [31:0] p);
        logic taken;
        fetch({6'h04, rs, rt, 16'd3});
        p = pc_m;
        decode();
        idle(); alusrca = 1; aluctrl = 3'b110; pcwritecond = 1; pcsource = 2'b01; bne = bne_v;
        tick();
        taken = bne_v ? (rf_m[rs] != rf_m[rt]) : (rf_m[rs] == rf_m[rt]);
        if (taken) pc_m = p + 32'd12;
        check($sformatf("branch r%0d r%0d bne=%0d pc", rs, rt, bne_v), pc_out, pc_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res, p;
        logic        z;
        logic [4:0]  ra, rb, rd;
        logic [2:0]  op;
        logic [31:0] expv;

        vecs[0]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0006, 1'b0};
        vecs[1]  = '{3'd2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[2]  = '{3'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[3]  = '{3'd6, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[5]  = '{3'd1, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
        vecs[6]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[7]  = '{3'd7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[8]  = '{3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[9]  = '{3'd3, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[10] = '{3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[11] = '{3'd5, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1};

        n_vec = 0;
        n_err = 0;
        idle();
        mem_rdata = 32'h0;
        rst = 0;
        tick();
        tick();

        check("reset pc_out", pc_out, PC_RST);
        check("reset instr", instr, 32'h0);
        check("reset aluout", aluout, 32'h0);
        check("reset mem_addr", mem_addr, PC_RST);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset pc_out nobne", pc_out_b, PC_RST);
        rst = 1;
        pc_m = PC_RST;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;

        fetch(32'h014B_4820);
        check("fetch instr", instr, 32'h014B_4820);
        check("fetch pc", pc_out, PC_RST + 32'd4);

        for (int i = 0; i < 12; i++) begin
            load_reg(5'd1, vecs[i].a);
            load_reg(5'd2, vecs[i].b);
            rtype(5'd1, 5'd2, 5'd3, vecs[i].op, res, z);
            check($sformatf("vec%0d aluout", i), res, vecs[i].exp);
            check($sformatf("vec%0d zero", i), {31'b0, z}, {31'b0, vecs[i].exp_zero});
        end
        check_reg(5'd3);

        load_reg(5'd10, 32'h0000_0007);
        load_reg(5'd11, 32'hFFFF_FFFF);
        rtype(5'd10, 5'd11, 5'd9, 3'd2, res, z);
        check("add aluout", res, 32'h0000_0006);
        check_reg(5'd9);

        load_reg(5'd1, 32'h0000_0100);
        fetch({6'h23, 5'd1, 5'd2, 16'd8});
        decode();
        idle(); alusrca = 1; alusrcb = 2'b10; tick();
        idle(); iord = 1;
        #1 check("lw mem_addr", mem_addr, 32'h0000_0108);
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        idle(); memtoreg = 1; regwrite = 1; mem_rdata = 32'h0; tick();
        rf_m[2] = 32'hDEAD_BEEF;
        check_reg(5'd2);

        fetch({6'h2B, 5'd1, 5'd11, 16'd4});
        decode();
        check("sw mem_wdata", mem_wdata, 32'hFFFF_FFFF);
        idle(); alusrca = 1; alusrcb = 2'b10; tick();
        idle(); iord = 1;
        #1 check("sw mem_addr", mem_addr, 32'h0000_0104);
        tick();

        load_reg(5'd1, 32'h0000_0055);
        load_reg(5'd2, 32'h0000_0055);
        load_reg(5'd3, 32'h0000_0066);
        branch(5'd1, 5'd2, 1'b0, p);
        branch(5'd1, 5'd2, 1'b1, p);
        check("bne ignored when disabled", pc_out_b, p + 32'd12);
        branch(5'd1, 5'd3, 1'b0, p);
        branch(5'd1, 5'd3, 1'b1, p);

        load_reg(5'd5, 32'h1000_0000);
        fetch({6'h00, 5'd5, 15'd0, 6'h08});
        decode();
        idle(); alusrca = 1; alusrcb = 2'b01; pcwrite = 1; tick();
        pc_m = 32'h1000_0004;
        check("pc from alu", pc_out, pc_m);
        fetch({6'h02, 26'h000_0040});
        decode();
        idle(); pcsource = 2'b10; pcwrite = 1; tick();
        pc_m = 32'h1000_0100;
        check("jump pc", pc_out, pc_m);
        idle(); pcsource = 2'b11; pcwrite = 1; tick();
        check("pc hold", pc_out, pc_m);

        rtype(5'd10, 5'd11, 5'd0, 3'd2, res, z);
        check_reg(5'd0);
        load_reg(5'd0, 32'h0000_ABCD);
        check_reg(5'd0);

        // add r3, r3, r4: the cycle after writeback still sees the old r3 in A
        load_reg(5'd3, 32'd10);
        load_reg(5'd4, 32'd5);
        fetch({6'h00, 5'd3, 5'd4, 5'd3, 5'd0, 6'h20});
        decode();
        idle(); alusrca = 1; tick();
        regdst = 1; regwrite = 1; tick();
        rf_m[3] = 32'd15;
        idle(); alusrca = 1; tick();
        check("raw old value", aluout, 32'd15);
        tick();
        check("raw new value", aluout, 32'd20);

        for (int i = 0; i < 8; i++) begin
            rd = 5'($urandom_range(1, 31));
            load_reg(rd, $urandom);
        end
        for (int i = 0; i < 30; i++) begin
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            op = 3'($urandom_range(0, 7));
            expv = model_alu(op, rf_m[ra], rf_m[rb]);
            rtype(ra, rb, rd, op, res, z);
            check($sformatf("rand%0d op%0d aluout", i, op), res, expv);
            check($sformatf("rand%0d zero", i), {31'b0, z}, {31'b0, (expv == 32'h0)});
        end
        for (int i = 0; i < 6; i++) check_reg(5'($urandom_range(0, 31)));

        load_reg(5'd21, 32'h0000_0777);
        fetch({6'h00, 5'd10, 5'd11, 5'd21, 5'd0, 6'h20});
        decode();
        idle(); alusrca = 1; tick();
        regdst = 1; regwrite = 1; pcwrite = 1; irwrite = 1; mem_rdata = 32'hFFFF_FFFF;
        rst = 0;
        tick();
        check("midreset pc", pc_out, PC_RST);
        check("midreset instr", instr, 32'h0);
        check("midreset aluout", aluout, 32'h0);
        idle();
        rst = 1;
        pc_m = PC_RST;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
        check_reg(5'd21);
        check_reg(5'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multicycle MIPS-subset datapath, the successor to the single-cycle datapath in the CPU lab. Instruction fetch and data access share one external memory port, and execution is split over cycles through architectural holding registers: PC, IR, MDR, A, B and ALUOut. The controller FSM is external and drives every control input each cycle. The datapath holds no hidden sequencing of its own.

## Interface
- WIDTH, 32, data/address width; must be ≥ 32. Instruction fields always come from IR[31:0].
- PC_RESET, 0, PC value loaded on reset.
- BNE_EN, 1, when 1 the `bne` input is honoured; when 0 it is treated as 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- iord  in  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  in  1  load IR from mem_rdata.
- pcwrite  in  1  unconditional PC load.
- pcwritecond  in  1  conditional PC load.
- bne  in  1  branch polarity: 0 = branch on zero, 1 = branch on non-zero.
- regdst  in  1  write address: 0 = IR[20:16], 1 = IR[15:11].
- memtoreg  in  1  write data: 0 = ALUOut, 1 = MDR.
- regwrite  in  1  register file write enable.
- alusrca  in  1  ALU operand A: 0 = PC, 1 = A.
- alusrcb  in  2  ALU operand B: 00 = B, 01 = 4, 10 = sext(imm16), 11 = sext(imm16)<<2.
- aluctrl  in  3  ALU operation (see Operation).
- pcsource  in  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = PC (hold).
- mem_rdata  in  WIDTH  memory read data.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  store data; equals B.
- instr  out  32  current IR.
- pc_out  out  WIDTH  current PC.
- aluout  out  WIDTH  ALUOut register.
- zero  out  1  combinational; high when the ALU result is 0.

## Operation
- Register file: 32 × WIDTH.
  - Two combinational read ports, addressed by rs = IR[25:21] and rt = IR[20:16].
  - One synchronous write port.
  - r0 always reads 0; writes to r0 are discarded.
- Every clock, unconditionally:
  - MDR ← mem_rdata
  - A ← rf[rs]
  - B ← rf[rt]
  - ALUOut ← ALU result
- Conditional updates:
  - IR ← mem_rdata only when irwrite = 1.
  - PC ← next PC when `pcwrite | (pcwritecond & (zero ^ (bne & BNE_EN)))` is true.
  - pcsource = 11 with a PC write asserted leaves PC unchanged.
- ALU operations (aluctrl), all results WIDTH bits, carries and overflow discarded (wrap-around):
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT, signed; result is 1 or 0, zero-extended.
  - 011, 100 and 101 produce 0.
- Sign extension: imm16 = IR[15:0], sign-extended to WIDTH bits.
- Jump target: {PC[WIDTH-1:28], IR[25:0], 2'b00}, using the current PC.
- mem_addr = iord ? ALUOut : PC (combinational).

## Timing
- Reset (rst = 0 at a rising edge):
  - PC ← PC_RESET.
  - IR, MDR, A, B and ALUOut ← 0.
  - All 32 registers ← 0.
  - Reset overrides every write enable asserted in the same cycle, including mid-instruction.
- Outputs immediately after reset: pc_out = PC_RESET, instr = 0, aluout = 0, mem_addr = PC_RESET (with iord = 0), mem_wdata = 0.
- Register file read/write timing:
  - A write takes effect at the edge. A read in the same cycle returns the old value, because A and B capture pre-write contents.
  - The new value is visible on the read ports in the following cycle.
- Combinational paths: zero and mem_addr follow the inputs within the cycle; no register is inserted.
- Canonical sequence driven by the external FSM:
  - fetch (1 cycle)
  - decode (1 cycle)
  - execute / address (1 cycle)
  - memory or writeback (1–2 cycles)
  - This gives lw = 5, sw = 4, R-type = 4, beq/bne = 3 and j = 3 cycles. The datapath imposes no latency of its own beyond one register stage per step.

## Test plan
- **Fetch:** reset, then rst = 1; mem_rdata = 0x014B4820; iord = 0, irwrite = 1, alusrca = 0, alusrcb = 01, aluctrl = 010, pcsource = 00, pcwrite = 1 for one edge.
  - Required: instr = 0x014B4820, pc_out = PC_RESET + 4.
- **R-type add:** preload r10 = 7, r11 = 0xFFFFFFFF via lw sequences; then decode, execute (alusrca = 1, alusrcb = 00, aluctrl = 010) and writeback (regdst = 1, regwrite = 1).
  - Required: r9 = 6 (wrap-around), aluout = 6.
- **lw:** r1 = 0x100, IR = lw r2, 8(r1); address step, then mem_rdata = 0xDEADBEEF with iord = 1.
  - Required: mem_addr = 0x108; r2 = 0xDEADBEEF after writeback with memtoreg = 1.
- **Branch polarity:** beq with r1 == r2 and offset 3, pcwritecond = 1, pcsource = 01.
  - Required: PC = PC+4 + 12.
  - Repeat with bne = 1: PC unchanged.
  - With BNE_EN = 0, the bne input is ignored.
- **Jump and r0:**
  - j 0x0000040 with PC = 0x1000_0004 → PC = 0x1000_0100.
  - Writeback targeting r0 → r0 still reads 0.
- **Reset mid-instruction:** assert rst = 0 during a writeback cycle with regwrite = 1 and pcwrite = 1.
  - Required: target register = 0, PC = PC_RESET, IR = 0.
